// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: one-cycle D->E transfer with flush/stall control,
// write-back bypass on capture and on hold, and optional performance counters
// enabled by the macro ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ValidD,
  input  logic               RegWriteD,
  input  logic               MemtoRegD,
  input  logic               MemWriteD,
  input  logic               ALUSrcD,
  input  logic               RegDstD,
  input  logic [ALUOP_W-1:0] ALUCtrlD,
  input  logic [1:0]         ExtOpD,
  input  logic [DATA_W-1:0]  RData1In,
  input  logic [DATA_W-1:0]  RData2In,
  input  logic [IMM_W-1:0]   ImmD,
  input  logic [REG_W-1:0]   RsD,
  input  logic [REG_W-1:0]   RtD,
  input  logic [REG_W-1:0]   RdD,
  input  logic               RegWriteW,
  input  logic [REG_W-1:0]   WriteRegW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic               ValidE,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               ALUSrcE,
  output logic               RegDstE,
  output logic [ALUOP_W-1:0] ALUCtrlE,
  output logic [DATA_W-1:0]  RData1E,
  output logic [DATA_W-1:0]  RData2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [REG_W-1:0]   RsE,
  output logic [REG_W-1:0]   RtE,
  output logic [REG_W-1:0]   RdE,
  output logic [REG_W-1:0]   WriteRegE,
  output logic [31:0]        StallCnt,
  output logic [31:0]        BubbleCnt
);

  localparam int PAD_W = DATA_W - IMM_W;

  // Immediate extension; the reserved mode 2'b11 behaves as zero extension.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic [1:0]       op);
    logic [DATA_W-1:0] res;
    case (op)
      2'b01:   res = {{PAD_W{imm[IMM_W-1]}}, imm};
      2'b10:   res = {imm, {PAD_W{1'b0}}};
      2'b00:   res = {{PAD_W{1'b0}}, imm};
      default: res = {{PAD_W{1'b0}}, imm};
    endcase
    return res;
  endfunction

  function automatic logic fwd_hit(input logic             we,
                                   input logic [REG_W-1:0] wreg,
                                   input logic [REG_W-1:0] src);
    return we && (wreg != {REG_W{1'b0}}) && (wreg == src);
  endfunction

  logic               valid_q, valid_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               memwrite_q, memwrite_d;
  logic               alusrc_q, alusrc_d;
  logic               regdst_q, regdst_d;
  logic [ALUOP_W-1:0] aluctrl_q, aluctrl_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d;
  logic [DATA_W-1:0]  rdata2_q, rdata2_d;
  logic [DATA_W-1:0]  immext_q, immext_d;
  logic [REG_W-1:0]   rs_q, rs_d;
  logic [REG_W-1:0]   rt_q, rt_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [REG_W-1:0]   writereg_q, writereg_d;

  // Next-state selection: Flush beats Stall, Stall beats capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    aluctrl_d  = aluctrl_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    immext_d   = immext_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    writereg_d = writereg_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      aluctrl_d  = {ALUOP_W{1'b0}};
      rdata1_d   = {DATA_W{1'b0}};
      rdata2_d   = {DATA_W{1'b0}};
      immext_d   = {DATA_W{1'b0}};
      rs_d       = {REG_W{1'b0}};
      rt_d       = {REG_W{1'b0}};
      rd_d       = {REG_W{1'b0}};
      writereg_d = {REG_W{1'b0}};
    end else if (Stall) begin
      // A held instruction must still see results retiring while it waits.
      if (fwd_hit(RegWriteW, WriteRegW, rs_q)) begin
        rdata1_d = ResultW;
      end else begin
        rdata1_d = rdata1_q;
      end
      if (fwd_hit(RegWriteW, WriteRegW, rt_q)) begin
        rdata2_d = ResultW;
      end else begin
        rdata2_d = rdata2_q;
      end
    end else begin
      valid_d    = ValidD;
      regwrite_d = RegWriteD;
      memtoreg_d = MemtoRegD;
      memwrite_d = MemWriteD;
      alusrc_d   = ALUSrcD;
      regdst_d   = RegDstD;
      aluctrl_d  = ALUCtrlD;
      immext_d   = ext_imm(ImmD, ExtOpD);
      rs_d       = RsD;
      rt_d       = RtD;
      rd_d       = RdD;
      if (RegDstD) begin
        writereg_d = RdD;
      end else begin
        writereg_d = RtD;
      end
      if (fwd_hit(RegWriteW, WriteRegW, RsD)) begin
        rdata1_d = ResultW;
      end else begin
        rdata1_d = RData1In;
      end
      if (fwd_hit(RegWriteW, WriteRegW, RtD)) begin
        rdata2_d = ResultW;
      end else begin
        rdata2_d = RData2In;
      end
    end
  end

  // E-stage state registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluctrl_q  <= {ALUOP_W{1'b0}};
      rdata1_q   <= {DATA_W{1'b0}};
      rdata2_q   <= {DATA_W{1'b0}};
      immext_q   <= {DATA_W{1'b0}};
      rs_q       <= {REG_W{1'b0}};
      rt_q       <= {REG_W{1'b0}};
      rd_q       <= {REG_W{1'b0}};
      writereg_q <= {REG_W{1'b0}};
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      aluctrl_q  <= aluctrl_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      immext_q   <= immext_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      writereg_q <= writereg_d;
    end
  end

  assign ValidE    = valid_q;
  assign RegWriteE = regwrite_q;
  assign MemtoRegE = memtoreg_q;
  assign MemWriteE = memwrite_q;
  assign ALUSrcE   = alusrc_q;
  assign RegDstE   = regdst_q;
  assign ALUCtrlE  = aluctrl_q;
  assign RData1E   = rdata1_q;
  assign RData2E   = rdata2_q;
  assign ImmExtE   = immext_q;
  assign RsE       = rs_q;
  assign RtE       = rt_q;
  assign RdE       = rd_q;
  assign WriteRegE = writereg_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters; a flush edge counts as a bubble, not a stall.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (Flush) begin
      if (bubble_cnt_q != 32'hFFFF_FFFF) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else if (Stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`else
  assign StallCnt  = 32'd0;
  assign BubbleCnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: each driven edge queues its expected
// E-stage image; a negedge monitor pops and compares every field.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clk, Rst_n, Stall, Flush;
  logic        ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUCtrlD;
  logic [1:0]  ExtOpD;
  logic [31:0] RData1In, RData2In, ResultW;
  logic [15:0] ImmD;
  logic [4:0]  RsD, RtD, RdD, WriteRegW;
  logic        RegWriteW;
  logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUCtrlE;
  logic [31:0] RData1E, RData2E, ImmExtE, StallCnt, BubbleCnt;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;

  typedef struct packed {
    logic        ve, rwe, m2re, mwe, asre, rdst;
    logic [2:0]  alu;
    logic [31:0] r1, r2, imm;
    logic [4:0]  rs, rt, rd, wr;
    logic [31:0] sc, bc;
  } exp_t;

  exp_t e;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_pipe_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .ALUCtrlD(ALUCtrlD), .ExtOpD(ExtOpD), .RData1In(RData1In), .RData2In(RData2In),
    .ImmD(ImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .ALUCtrlE(ALUCtrlE), .RData1E(RData1E), .RData2E(RData2E), .ImmExtE(ImmExtE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
    .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  int step_mon = 0;

  // Monitor: one expected image per clock edge, checked mid-cycle.
  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t m;
      m = sb_q.pop_front();
      step_mon++;
      chk("ValidE",    step_mon, 32'(ValidE),    32'(m.ve));
      chk("RegWriteE", step_mon, 32'(RegWriteE), 32'(m.rwe));
      chk("MemtoRegE", step_mon, 32'(MemtoRegE), 32'(m.m2re));
      chk("MemWriteE", step_mon, 32'(MemWriteE), 32'(m.mwe));
      chk("ALUSrcE",   step_mon, 32'(ALUSrcE),   32'(m.asre));
      chk("RegDstE",   step_mon, 32'(RegDstE),   32'(m.rdst));
      chk("ALUCtrlE",  step_mon, 32'(ALUCtrlE),  32'(m.alu));
      chk("RData1E",   step_mon, RData1E,        m.r1);
      chk("RData2E",   step_mon, RData2E,        m.r2);
      chk("ImmExtE",   step_mon, ImmExtE,        m.imm);
      chk("RsE",       step_mon, 32'(RsE),       32'(m.rs));
      chk("RtE",       step_mon, 32'(RtE),       32'(m.rt));
      chk("RdE",       step_mon, 32'(RdE),       32'(m.rd));
      chk("WriteRegE", step_mon, 32'(WriteRegE), 32'(m.wr));
      chk("StallCnt",  step_mon, StallCnt,       m.sc);
      chk("BubbleCnt", step_mon, BubbleCnt,      m.bc);
    end
  end

  task automatic tick();
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset edge with every other input driven high.
    Rst_n = 1'b0; Stall = 1'b1; Flush = 1'b1;
    ValidD = 1'b1; RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1;
    ALUSrcD = 1'b1; RegDstD = 1'b1; ALUCtrlD = 3'b111; ExtOpD = 2'b11;
    RData1In = 32'hFFFF_FFFF; RData2In = 32'hFFFF_FFFF; ImmD = 16'hFFFF;
    RsD = 5'd31; RtD = 5'd31; RdD = 5'd31;
    RegWriteW = 1'b1; WriteRegW = 5'd31; ResultW = 32'hFFFF_FFFF;
    e = '0;
    tick();

    // Extension modes.
    Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    ValidD = 1'b1; RegWriteD = 1'b1; MemtoRegD = 1'b0; MemWriteD = 1'b1;
    ALUSrcD = 1'b1; RegDstD = 1'b0; ALUCtrlD = 3'd5; ExtOpD = 2'b01;
    RData1In = 32'h11; RData2In = 32'h22; ImmD = 16'h8001;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd3;
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'h0;
    e.ve = 1'b1; e.rwe = 1'b1; e.m2re = 1'b0; e.mwe = 1'b1; e.asre = 1'b1;
    e.rdst = 1'b0; e.alu = 3'd5; e.r1 = 32'h11; e.r2 = 32'h22;
    e.imm = 32'hFFFF_8001; e.rs = 5'd1; e.rt = 5'd2; e.rd = 5'd3; e.wr = 5'd2;
    tick();
    ExtOpD = 2'b00; e.imm = 32'h0000_8001; tick();
    ExtOpD = 2'b10; e.imm = 32'h8001_0000; tick();
    ExtOpD = 2'b11; e.imm = 32'h0000_8001; tick();

    // Destination register select.
    ExtOpD = 2'b00; RegDstD = 1'b1; RdD = 5'd7; RtD = 5'd9;
    e.rdst = 1'b1; e.rt = 5'd9; e.rd = 5'd7; e.wr = 5'd7;
    tick();
    RegDstD = 1'b0; e.rdst = 1'b0; e.wr = 5'd9; tick();

    // Capture bypass, then register-0 and write-disabled cases.
    RsD = 5'd5; RtD = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
    ResultW = 32'hDEAD_BEEF; RData1In = 32'h1; RData2In = 32'h2;
    e.rs = 5'd5; e.rt = 5'd5; e.wr = 5'd5; e.r1 = 32'hDEAD_BEEF; e.r2 = 32'hDEAD_BEEF;
    tick();
    WriteRegW = 5'd0; e.r1 = 32'h1; e.r2 = 32'h2; tick();
    RsD = 5'd0; RtD = 5'd0; e.rs = 5'd0; e.rt = 5'd0; e.wr = 5'd0; tick();
    RsD = 5'd5; RtD = 5'd5; WriteRegW = 5'd5; RegWriteW = 1'b0;
    e.rs = 5'd5; e.rt = 5'd5; e.wr = 5'd5; tick();

    // Capture for the stall sequence.
    RsD = 5'd3; RtD = 5'd4; RData1In = 32'hAAAA; RData2In = 32'hBBBB;
    WriteRegW = 5'd0;
    e.rs = 5'd3; e.rt = 5'd4; e.wr = 5'd4; e.r1 = 32'hAAAA; e.r2 = 32'hBBBB;
    tick();

    // Three stall cycles with changing D inputs; write-back to r3 in the second.
    Stall = 1'b1; ValidD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0;
    ALUCtrlD = 3'd0; ImmD = 16'h0; RsD = 5'd8; RtD = 5'd8; RdD = 5'd8;
    RData1In = 32'h5555; RData2In = 32'h6666;
    e.sc = PERF ? 32'd1 : 32'd0;
    tick();
    RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'h1234;
    e.r1 = 32'h1234; e.sc = PERF ? 32'd2 : 32'd0;
    tick();
    RegWriteW = 1'b0; e.sc = PERF ? 32'd3 : 32'd0; tick();

    // Stall and Flush together produce a bubble.
    Flush = 1'b1;
    e.ve = 1'b0; e.rwe = 1'b0; e.m2re = 1'b0; e.mwe = 1'b0; e.asre = 1'b0;
    e.rdst = 1'b0; e.alu = 3'd0; e.r1 = 32'h0; e.r2 = 32'h0; e.imm = 32'h0;
    e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0; e.wr = 5'd0;
    e.bc = PERF ? 32'd1 : 32'd0;
    tick();

    // Fresh capture, then reset while stalled.
    Stall = 1'b0; Flush = 1'b0;
    ValidD = 1'b1; RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1;
    ALUSrcD = 1'b0; ALUCtrlD = 3'd5; ImmD = 16'h8001; ExtOpD = 2'b00;
    RsD = 5'd6; RtD = 5'd2; RdD = 5'd3; RData1In = 32'h66; RData2In = 32'h77;
    e.ve = 1'b1; e.rwe = 1'b1; e.m2re = 1'b1; e.mwe = 1'b1; e.asre = 1'b0;
    e.rdst = 1'b0; e.alu = 3'd5; e.r1 = 32'h66; e.r2 = 32'h77; e.imm = 32'h0000_8001;
    e.rs = 5'd6; e.rt = 5'd2; e.rd = 5'd3; e.wr = 5'd2;
    tick();
    Stall = 1'b1; Rst_n = 1'b0; e = '0; tick();

    // Stall after release holds zeros; a write to r0 must not bypass.
    Rst_n = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFF;
    e.sc = PERF ? 32'd1 : 32'd0;
    tick();

    // Normal capture resumes.
    Stall = 1'b0; RegWriteW = 1'b0;
    e.ve = 1'b1; e.rwe = 1'b1; e.m2re = 1'b1; e.mwe = 1'b1; e.asre = 1'b0;
    e.rdst = 1'b0; e.alu = 3'd5; e.r1 = 32'h66; e.r2 = 32'h77; e.imm = 32'h0000_8001;
    e.rs = 5'd6; e.rt = 5'd2; e.rd = 5'd3; e.wr = 5'd2;
    tick();

    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
